// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS32 pipeline hazard controller: load-use stalls, branch flushes, HI/LO interlock
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_muldiv,
    input  logic        id_is_div,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MUL_LAT = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_LAT = 8'(DIV_CYCLES);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    logic w_busy;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_hilo_hz;
    logic w_stall;
    logic w_start;
    logic w_count_stall;

    // A load writing $0 never produces a usable value, so it can never be a hazard.
    assign w_busy     = (r_state == ST_BUSY);
    assign w_rs_hit   = id_uses_rs & (id_rs == ex_rd);
    assign w_rt_hit   = id_uses_rt & (id_rt == ex_rd);
    assign w_load_use = ex_mem_read & (ex_rd != 5'd0) & (w_rs_hit | w_rt_hit);
    assign w_hilo_hz  = w_busy & (id_is_muldiv | id_reads_hilo);
    assign w_stall    = w_load_use | w_hilo_hz;

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        w_start    = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else begin
            w_start = id_is_muldiv;
        end
    end

    assign muldiv_start  = w_start;
    assign muldiv_busy   = w_busy & ~reset;
    assign w_count_stall = w_stall & ~ex_branch_taken;

    // Once issued, the operation no longer lives in ID, so a flush must not abort it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= id_is_div ? DIV_LAT : MUL_LAT;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (w_count_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (ex_branch_taken && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div, id_reads_hilo;
    logic        ex_mem_read, ex_branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, muldiv_start, muldiv_busy;
    logic [15:0] stall_cycles, flush_count;

    hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_is_muldiv   (id_is_muldiv),
        .id_is_div      (id_is_div),
        .id_reads_hilo  (id_reads_hilo),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .muldiv_start   (muldiv_start),
        .muldiv_busy    (muldiv_busy),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_flush;
        logic        muldiv_start;
        logic        muldiv_busy;
        logic [15:0] stall_cycles;
        logic [15:0] flush_count;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          m_left = 0;
    logic [15:0] m_stall = 16'd0;
    logic [15:0] m_flush = 16'd0;

    function automatic exp_t obs();
        obs = {pc_write, ifid_write, ifid_flush, idex_flush, muldiv_start, muldiv_busy,
               stall_cycles, flush_count};
    endfunction

    function automatic logic model_stall();
        logic lu;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        return lu || ((m_left > 0) && (id_is_muldiv || id_reads_hilo));
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.stall_cycles = m_stall;
        e.flush_count  = m_flush;
        e.muldiv_busy  = !reset && (m_left > 0);
        if (reset)                {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.muldiv_start} = 5'b00110;
        else if (ex_branch_taken) {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.muldiv_start} = 5'b11110;
        else if (model_stall())   {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.muldiv_start} = 5'b00010;
        else                      {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.muldiv_start} = {4'b1100, id_is_muldiv};
        return e;
    endfunction

    task automatic clear_inputs();
        reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_muldiv = 1'b0; id_is_div = 1'b0;
        id_reads_hilo = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    // Push this cycle's expectation, then move to the sampling point (falling edge).
    task automatic settle();
        sb.push_back(predict());
        @(negedge clock);
    endtask

    // Clock the DUT and the reference model with the inputs currently applied.
    task automatic advance();
        exp_t e;
        logic st;
        e  = predict();
        st = model_stall() && !ex_branch_taken;
        @(posedge clock);
        if (reset) begin
            m_left = 0; m_stall = 16'd0; m_flush = 16'd0;
        end else begin
            if (st && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (ex_branch_taken && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
            if (m_left > 0) m_left = m_left - 1;
            else if (e.muldiv_start) m_left = id_is_div ? 32 : 4;
        end
        #1;
    endtask

    task automatic test_reset();
        exp_t got, e;
        clear_inputs();
        reset = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset cyc%0d got=%h exp=%h", k, got, e); end
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        exp_t got, e;
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin ex_mem_read = 1'b1; ex_rd = 5'd2; end
            else        begin ex_mem_read = 1'b0; ex_rd = 5'd0; end
            id_rs = 5'd2; id_uses_rs = 1'b1;
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL load_use cyc%0d got=%h exp=%h", k, got, e); end
            if (k == 0) begin
                vectors++;
                if ({pc_write, ifid_write, idex_flush} !== 3'b001) begin
                    miscompares++; $display("FAIL load_use_ctl got=%b exp=001", {pc_write, ifid_write, idex_flush});
                end
            end
            advance();
        end
        vectors++;
        if (stall_cycles !== 16'd1) begin miscompares++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_no_stall();
        exp_t got, e;
        // {ex_rd, id_rs, id_rt, uses_rs, uses_rt}: rd0, rs-unused, rt hit, rt-unused
        logic [16:0] vecs [4] = '{ {5'd0, 5'd0, 5'd9, 1'b1, 1'b0},
                                   {5'd7, 5'd7, 5'd1, 1'b0, 1'b0},
                                   {5'd5, 5'd1, 5'd5, 1'b1, 1'b1},
                                   {5'd6, 5'd3, 5'd6, 1'b1, 1'b0} };
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            ex_mem_read = 1'b1;
            {ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt} = vecs[k];
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL no_stall vec%0d got=%h exp=%h", k, got, e); end
            advance();
        end
    endtask

    task automatic test_mult_hilo();
        exp_t got, e;
        int starts, stalls;
        clear_inputs(); reset = 1'b1; advance(); reset = 1'b0;
        starts = 0; stalls = 0;
        for (int k = 0; k < 6; k++) begin
            id_is_muldiv  = (k == 0);
            id_reads_hilo = (k != 0);
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mult cyc%0d got=%h exp=%h", k, got, e); end
            if (muldiv_start) starts++;
            if (!pc_write) stalls++;
            advance();
        end
        vectors++;
        if (starts !== 1 || stalls !== 4 || stall_cycles !== 16'd4) begin
            miscompares++;
            $display("FAIL mult_summary got starts=%0d stalls=%0d cnt=%0d exp 1/4/4", starts, stalls, stall_cycles);
        end
    endtask

    task automatic test_div_flush();
        exp_t got, e;
        int busy;
        clear_inputs(); reset = 1'b1; advance(); reset = 1'b0;
        busy = 0;
        for (int k = 0; k < 34; k++) begin
            id_is_muldiv    = (k == 0);
            id_is_div       = (k == 0);
            id_reads_hilo   = (k != 0);
            ex_branch_taken = (k == 3);
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL div_flush cyc%0d got=%h exp=%h", k, got, e); end
            if (muldiv_busy) busy++;
            advance();
        end
        vectors++;
        if (busy !== 32 || flush_count !== 16'd1 || stall_cycles !== 16'd31) begin
            miscompares++;
            $display("FAIL div_summary got busy=%0d flush=%0d stall=%0d exp 32/1/31", busy, flush_count, stall_cycles);
        end
    endtask

    task automatic test_flush_priority();
        exp_t got, e;
        clear_inputs(); reset = 1'b1; advance(); reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ex_branch_taken = (k == 0);
            ex_mem_read = (k == 0); ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
            id_is_muldiv = (k == 0);
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL flush_prio cyc%0d got=%h exp=%h", k, got, e); end
            if (k == 1) begin
                vectors++;
                if (muldiv_busy !== 1'b0 || stall_cycles !== 16'd0 || flush_count !== 16'd1) begin
                    miscompares++;
                    $display("FAIL flush_prio_state got busy=%b stall=%0d flush=%0d exp 0/0/1", muldiv_busy, stall_cycles, flush_count);
                end
            end
            advance();
        end
    endtask

    task automatic test_saturate();
        exp_t got, e;
        clear_inputs(); reset = 1'b1; advance(); reset = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL saturate cyc%0d got=%h exp=%h", k, got, e); end
            advance();
        end
        vectors++;
        if (stall_cycles !== 16'hFFFF) begin miscompares++; $display("FAIL saturate_hold got=%h exp=ffff", stall_cycles); end
    endtask

    task automatic test_reset_mid_busy();
        exp_t got, e;
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            id_is_muldiv = (k == 0);
            id_is_div    = (k == 0);
            reset        = (k >= 5 && k <= 7);
            settle();
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset_busy cyc%0d got=%h exp=%h", k, got, e); end
            advance();
        end
        vectors++;
        if (muldiv_busy !== 1'b0 || stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_busy_state got busy=%b stall=%0d flush=%0d exp 0/0/0", muldiv_busy, stall_cycles, flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mult_hilo();
        test_div_flush();
        test_flush_priority();
        test_saturate();
        test_reset_mid_busy();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS32 core. Sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use stalls, branch/jump flushes, and HI/LO interlocks for the multi-cycle multiply/divide unit. It drives the PC/IF-ID write enables and the IF-ID/ID-EX flush controls, sequences issue to the mult/div unit, and keeps saturating stall/flush performance counters.

## Interface
- MUL_CYCLES, 4, multiply latency in cycles (1..255)
- DIV_CYCLES, 32, divide latency in cycles (1..255)

- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_is_div  in  1  qualifies id_is_muldiv: 1 = divide, 0 = multiply
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken (PC target valid this cycle)
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  zero the IF/ID register (insert NOP)
- idex_flush  out  1  zero ID/EX control bits (insert bubble)
- muldiv_start  out  1  one-cycle issue pulse to mult/div unit
- muldiv_busy  out  1  mult/div result not yet written to HI/LO
- stall_cycles  out  16  saturating count of stall cycles
- flush_count  out  16  saturating count of taken-branch flushes

## Operation
- Hazard terms, evaluated combinationally each cycle:
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))
  - hilo_hz = muldiv_busy & (id_is_muldiv | id_reads_hilo)
  - stall = load_use | hilo_hz
- Priority: flush > stall > normal.
  - ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, muldiv_start=0. Any stall is dropped (the stalled instruction is squashed).
  - stall (no flush): pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, muldiv_start=0.
  - normal: pc_write=1, ifid_write=1, both flushes 0; muldiv_start = id_is_muldiv.
- Mult/div FSM, states IDLE and BUSY, with an 8-bit down-counter cnt:
  - IDLE: on a muldiv_start edge, load cnt = DIV_CYCLES when id_is_div, else MUL_CYCLES; go to BUSY.
  - BUSY: decrement cnt on each edge; the edge with cnt==1 returns to IDLE. A flush does not abort BUSY, because the operation has already left ID.
  - muldiv_busy = (state == BUSY).
  - No new start is possible while BUSY, since hilo_hz stalls it.
- Counters: stall_cycles increments on each edge where stall & ~ex_branch_taken. flush_count increments on each edge where ex_branch_taken. Both saturate at 16'hFFFF and hold there.

## Timing
- Control outputs are combinational from inputs and registered state, with zero-cycle latency. FSM, cnt and counters update on the rising edge of clock.
- Reset (sampled at edge): state=IDLE, cnt=0, stall_cycles=0, flush_count=0.
- While reset is high, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, muldiv_start=0, muldiv_busy=0. Counters do not increment.
- Reset mid-BUSY returns to IDLE at that edge, and muldiv_busy is 0 in the next cycle.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM, ex_mem_read clears, and forwarding supplies the value.
- Mult/div: start in cycle T gives muldiv_busy=1 in cycles T+1..T+LAT. A dependent mfhi/mflo/muldiv in ID stalls T+1..T+LAT and advances in T+LAT+1.
- ex_rd == 0 never causes a stall. A simultaneous load_use and hilo_hz produces a single stall cycle.

## Test plan
- lw $2 in EX (ex_mem_read=1, ex_rd=2), ID add with id_rs=2, id_uses_rs=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle all normal; stall_cycles=1.
- Same as above but ex_rd=0, or id_uses_rs=0 -> no stall, pc_write=1.
- mult issued at T (MUL_CYCLES=4), mflo in ID at T+1 -> muldiv_start=1 at T only; muldiv_busy=1 for T+1..T+4; stall T+1..T+4; mflo advances at T+5; stall_cycles=4.
- div issued, then ex_branch_taken during BUSY with a mflo in ID -> ifid_flush=1, idex_flush=1, pc_write=1, no stall counted; muldiv_busy stays high for the full 32 cycles; flush_count=1.
- ex_branch_taken with a load-use hazard and id_is_muldiv in ID at the same cycle -> flush wins; muldiv_start=0; FSM stays IDLE.
- Force stall for 70000 cycles -> stall_cycles holds 16'hFFFF. Assert reset mid-BUSY -> counters=0, muldiv_busy=0 after the edge, and the reset output values hold while reset is high.
